// File: rtl/comma_word_aligner.sv
// Purpose  : aligns bit-rotated 10-bit deserializer words to 8b10b symbol boundaries by hunting K28.5 commas.
// Latency  : 1 WCLK from RX_WORD to DATA once locked; DATA_VALID pulses once per accepted word.
// Backpress: none; RX_VALID gaps freeze window and counters, and lock is dropped on repeated decoder errors.
//
// Ports: WCLK/RESET (sync, active-high) | RX_WORD/RX_VALID raw input | DECODER_ERR error for last DATA
//        DATA/DATA_VALID aligned symbol | SYNC_READY lock | ALIGN_OFFSET bit offset | REALIGN_CNT lock losses
// Optional build macro: ALIGNER_STATS_EN enables the REALIGN_CNT lock-loss counter (otherwise tied to 0).
module comma_word_aligner #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 8
) (
    input  logic       WCLK,
    input  logic       RESET,
    input  logic [9:0] RX_WORD,
    input  logic       RX_VALID,
    input  logic       DECODER_ERR,
    output logic [9:0] DATA,
    output logic       DATA_VALID,
    output logic       SYNC_READY,
    output logic [3:0] ALIGN_OFFSET,
    output logic [7:0] REALIGN_CNT
);
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [3:0] LOCK_THR  = 4'(LOCK_COUNT);
    localparam logic [7:0] LOSS_THR  = 8'(LOSS_COUNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [9:0] prev_q, prev_d;
    logic       have_prev_q, have_prev_d;
    logic [3:0] offset_q, offset_d;
    logic [3:0] ccnt_q, ccnt_d;
    logic [7:0] ecnt_q, ecnt_d;
    logic [9:0] data_q, data_d;
    logic       dvld_q, dvld_d;
    logic       dvld_dly_q, dvld_dly_d;   // DATA_VALID as seen one cycle ago

    logic [19:0] win;
    logic        comma_hit;
    logic [3:0]  comma_off;
    logic [9:0]  aligned;
    logic [3:0]  ccnt_inc;
    logic [7:0]  ecnt_inc;
    logic        err_evt;
    logic        loss_evt;

    assign win      = {prev_q, RX_WORD};
    // Candidate k is win[19-k -: 10], i.e. the window shifted right by 10-k.
    assign aligned  = 10'(win >> (4'd10 - offset_q));
    assign ccnt_inc = (ccnt_q == 4'hF)  ? ccnt_q : ccnt_q + 4'd1;
    assign ecnt_inc = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;

    // The decoder reports on the word shown one cycle earlier, so an error only
    // counts when DATA_VALID was high in that earlier cycle.
    assign err_evt  = (state_q == LOCKED) && dvld_dly_q && DECODER_ERR;
    assign loss_evt = err_evt && (ecnt_inc >= LOSS_THR);

    // Scan from high to low offset so the lowest matching offset wins.
    always_comb begin
        comma_hit = 1'b0;
        comma_off = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (win[19-k -: 10] == K28_5_NEG || win[19-k -: 10] == K28_5_POS) begin
                comma_hit = 1'b1;
                comma_off = 4'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        offset_d    = offset_q;
        ccnt_d      = ccnt_q;
        ecnt_d      = ecnt_q;
        data_d      = data_q;
        dvld_d      = 1'b0;
        dvld_dly_d  = dvld_q;

        if (RX_VALID) begin
            prev_d      = RX_WORD;
            have_prev_d = 1'b1;
        end

        unique case (state_q)
            HUNT: begin
                // The very first word after reset only primes prev.
                if (RX_VALID && have_prev_q && comma_hit) begin
                    offset_d = comma_off;
                    ccnt_d   = 4'd1;
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (RX_VALID && comma_hit) begin
                    if (comma_off == offset_q) begin
                        ccnt_d = ccnt_inc;
                        if (ccnt_inc >= LOCK_THR) begin
                            // The locking comma is itself emitted.
                            state_d = LOCKED;
                            data_d  = aligned;
                            dvld_d  = 1'b1;
                        end
                    end else begin
                        offset_d = comma_off;
                        ccnt_d   = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (dvld_dly_q) begin
                    ecnt_d = DECODER_ERR ? ecnt_inc : 8'd0;
                end
                if (loss_evt) begin
                    state_d = HUNT;
                    ecnt_d  = 8'd0;
                    ccnt_d  = 4'd0;
                end else if (RX_VALID) begin
                    data_d = aligned;
                    dvld_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            state_q     <= HUNT;
            prev_q      <= 10'd0;
            have_prev_q <= 1'b0;
            offset_q    <= 4'd0;
            ccnt_q      <= 4'd0;
            ecnt_q      <= 8'd0;
            data_q      <= 10'd0;
            dvld_q      <= 1'b0;
            dvld_dly_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            offset_q    <= offset_d;
            ccnt_q      <= ccnt_d;
            ecnt_q      <= ecnt_d;
            data_q      <= data_d;
            dvld_q      <= dvld_d;
            dvld_dly_q  <= dvld_dly_d;
        end
    end

`ifdef ALIGNER_STATS_EN
    logic [7:0] rcnt_q, rcnt_d;

    always_comb begin
        rcnt_d = rcnt_q;
        if (loss_evt && rcnt_q != 8'hFF) begin
            rcnt_d = rcnt_q + 8'd1;
        end
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            rcnt_q <= 8'd0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    assign REALIGN_CNT = rcnt_q;
`else
    assign REALIGN_CNT = 8'h00;
`endif

    assign DATA         = data_q;
    assign DATA_VALID   = dvld_q;
    assign SYNC_READY   = (state_q == LOCKED);
    assign ALIGN_OFFSET = offset_q;

endmodule

// File: tb/tb_comma_word_aligner.sv
// Purpose  : self-checking bench for comma_word_aligner using a bit-stream stimulus and a behavioural model.
// Latency  : model outputs compared 1 time unit after every WCLK rising edge.
// Backpress: none; RX_VALID gaps are driven explicitly.
module tb_comma_word_aligner;
    localparam int LOCK = 4;
    localparam int LOSS = 8;
    localparam logic [9:0] COMMA_N = 10'b0011111010;
    localparam logic [9:0] COMMA_P = 10'b1100000101;
    localparam logic [9:0] FILL    = 10'b1010101010;

    logic       WCLK;
    logic       RESET;
    logic [9:0] RX_WORD;
    logic       RX_VALID;
    logic       DECODER_ERR;
    logic [9:0] DATA;
    logic       DATA_VALID;
    logic       SYNC_READY;
    logic [3:0] ALIGN_OFFSET;
    logic [7:0] REALIGN_CNT;

    comma_word_aligner #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
        .WCLK(WCLK), .RESET(RESET), .RX_WORD(RX_WORD), .RX_VALID(RX_VALID),
        .DECODER_ERR(DECODER_ERR), .DATA(DATA), .DATA_VALID(DATA_VALID),
        .SYNC_READY(SYNC_READY), .ALIGN_OFFSET(ALIGN_OFFSET), .REALIGN_CNT(REALIGN_CNT)
    );

    initial WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

`ifdef ALIGNER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int S_HUNT = 0, S_VERIFY = 1, S_LOCKED = 2;
    int       m_state, m_off, m_ccnt, m_ecnt, m_losses;
    bit [9:0] m_prev, m_data;
    bit       m_have, m_dv, m_dv_last;

    function automatic int find_comma(input bit [19:0] w);
        bit [9:0] c;
        for (int k = 0; k < 10; k++) begin
            c = 10'(w >> (10 - k));
            if (c == COMMA_N || c == COMMA_P) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [9:0] w, input logic v, input logic e);
        bit [19:0] win;
        int        k;
        bit        dv_new;
        bit        lost;
        if (rst) begin
            m_state = S_HUNT; m_off = 0; m_ccnt = 0; m_ecnt = 0; m_losses = 0;
            m_prev = '0; m_data = '0; m_have = 0; m_dv = 0; m_dv_last = 0;
            return;
        end
        win    = {m_prev, w};
        k      = (v && m_have) ? find_comma(win) : -1;
        dv_new = 0;
        lost   = 0;
        if (m_state == S_LOCKED) begin
            if (m_dv_last) begin
                if (e) begin
                    if (m_ecnt < 255) m_ecnt++;
                    lost = (m_ecnt >= LOSS);
                end else begin
                    m_ecnt = 0;
                end
            end
            if (lost) begin
                m_state = S_HUNT; m_ecnt = 0; m_ccnt = 0;
                if (m_losses < 255) m_losses++;
            end else if (v) begin
                m_data = 10'(win >> (10 - m_off));
                dv_new = 1;
            end
        end else if (k >= 0) begin
            if (m_state == S_HUNT || k != m_off) begin
                m_off = k; m_ccnt = 1; m_state = S_VERIFY;
            end else begin
                if (m_ccnt < 15) m_ccnt++;
                if (m_ccnt >= LOCK) begin
                    m_state = S_LOCKED;
                    m_data  = 10'(win >> (10 - m_off));
                    dv_new  = 1;
                end
            end
        end
        if (v) begin
            m_prev = w; m_have = 1;
        end
        m_dv_last = m_dv;
        m_dv      = dv_new;
    endtask

    // Single compare process: model advanced on each edge, DUT sampled 1 unit later.
    always begin
        @(posedge WCLK);
        model_edge(RESET, RX_WORD, RX_VALID, DECODER_ERR);
        #1;
        check("data",   DATA,         m_data);
        check("dvalid", DATA_VALID,   m_dv);
        check("sync",   SYNC_READY,   (m_state == S_LOCKED) ? 1 : 0);
        check("offset", ALIGN_OFFSET, m_off);
        check("rcnt",   REALIGN_CNT,  STATS ? m_losses : 0);
    end

    // ---------------- bit-stream stimulus ----------------
    bit bq[$];

    task automatic push_sym(input logic [9:0] s, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
    endtask

    task automatic take_word(output logic [9:0] w);
        for (int i = 9; i >= 0; i--) w[i] = (bq.size() > 0) ? bq.pop_front() : (i % 2 == 1);
    endtask

    task automatic cyc(input logic rst, input logic v, input logic e);
        logic [9:0] w;
        w = '0;
        if (v) take_word(w);
        RESET = rst; RX_VALID = v; RX_WORD = w; DECODER_ERR = e;
        @(negedge WCLK);
    endtask

    task automatic words(input int n, input logic e);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, e);
    endtask

    int pulses;

    initial begin
        RESET = 1'b1; RX_VALID = 1'b0; RX_WORD = '0; DECODER_ERR = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("rst_sync", SYNC_READY, 0);
        check("rst_dv",   DATA_VALID, 0);
        check("rst_data", DATA, 0);
        check("rst_off",  ALIGN_OFFSET, 0);

        // Comma rotated by 3: first word primes, next four carry commas at offset 3.
        bq.delete(); push_junk(3); push_sym(COMMA_N, 4); push_sym(FILL, 20);
        words(4, 1'b0);
        check("a_sync_before", SYNC_READY, 0);
        words(1, 1'b0);
        check("a_sync_lock", SYNC_READY, 1);
        check("a_off", ALIGN_OFFSET, 3);
        check("a_data", DATA, COMMA_N);
        check("a_dv", DATA_VALID, 1);
        words(3, 1'b0);
        words(7, 1'b1);
        check("a_sync_7err", SYNC_READY, 1);
        words(1, 1'b1);
        check("a_sync_8err", SYNC_READY, 0);
        check("a_dv_8err", DATA_VALID, 0);
        check("a_rcnt", REALIGN_CNT, STATS);

        // Relock, then a single-cycle reset while locked.
        bq.delete(); push_junk(3); push_sym(COMMA_N, 4); push_sym(FILL, 10);
        words(5, 1'b0);
        check("r_sync_lock", SYNC_READY, 1);
        words(2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("r_sync", SYNC_READY, 0);
        check("r_dv", DATA_VALID, 0);
        check("r_data", DATA, 0);
        check("r_off", ALIGN_OFFSET, 0);
        check("r_rcnt", REALIGN_CNT, 0);
        bq.delete(); push_junk(3); push_sym(COMMA_N, 5); push_sym(FILL, 10);
        words(4, 1'b0);
        check("r_sync_3commas", SYNC_READY, 0);
        words(1, 1'b0);
        check("r_sync_relock", SYNC_READY, 1);
        check("r_off_relock", ALIGN_OFFSET, 3);

        // Two commas at offset 5, then the alignment moves to offset 2.
        cyc(1'b1, 1'b0, 1'b0);
        bq.delete(); push_junk(5); push_sym(COMMA_N, 2); push_junk(7);
        push_sym(COMMA_N, 4); push_sym(FILL, 40);
        words(3, 1'b0);
        check("b_off5", ALIGN_OFFSET, 5);
        words(2, 1'b0);
        check("b_off2", ALIGN_OFFSET, 2);
        check("b_sync_new", SYNC_READY, 0);
        words(2, 1'b0);
        check("b_sync_3", SYNC_READY, 0);
        words(1, 1'b0);
        check("b_sync_lock", SYNC_READY, 1);
        check("b_data_lock", DATA, COMMA_N);

        // Gapped input while locked: 1,0,0,1.
        pulses = 0;
        cyc(1'b0, 1'b1, 1'b0); pulses += int'(DATA_VALID);
        check("g_data", DATA, FILL);
        cyc(1'b0, 1'b0, 1'b0); pulses += int'(DATA_VALID);
        check("g_data_gap1", DATA, FILL);
        cyc(1'b0, 1'b0, 1'b0); pulses += int'(DATA_VALID);
        check("g_data_gap2", DATA, FILL);
        check("g_off_gap", ALIGN_OFFSET, 2);
        cyc(1'b0, 1'b1, 1'b0); pulses += int'(DATA_VALID);
        check("g_pulses", pulses, 2);

        // 7 errors, 1 clean, 7 errors: lock held; one more error drops it.
        words(2, 1'b0);
        words(7, 1'b1);
        words(1, 1'b0);
        words(7, 1'b1);
        check("e_sync_held", SYNC_READY, 1);
        words(1, 1'b1);
        check("e_sync_lost", SYNC_READY, 0);
        check("e_rcnt", REALIGN_CNT, STATS);

        cyc(1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
